key_arbiter: RTL and testbench

KEY_ARBITER -- requirements
Module: key_arbiter

---
 rtl/key_arbiter.sv | 143 ++++++++++++++
 tb/tb_key_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_arbiter.sv
// Merges keyboard and push-button key strobes into one FIFO and issues them
// to the game FSM as single-cycle pulses spaced GAP cycles apart.
module key_arbiter #(
  parameter int GAP   = 4,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [2:0]                 i_KBD_VALUE,
  input  logic                       i_KBD_VALID,
  input  logic [2:0]                 i_BTN_VALUE,
  input  logic                       i_BTN_VALID,
  input  logic                       i_FLUSH,
  output logic [2:0]                 o_KEY_VALUE,
  output logic                       o_KEY_VALID,
  output logic                       o_KEY_SRC,
  output logic [$clog2(DEPTH):0]     o_COUNT,
  output logic                       o_DROP
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t          r_state, w_next;
  logic [3:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [3:0]      r_gap;
  logic            r_prio;
  logic [2:0]      r_key_value;
  logic            r_key_valid, r_key_src, r_drop;

  logic            w_kbd_ok, w_btn_ok, w_both, w_pop_slot, w_pop;
  logic [CW-1:0]   w_free;
  logic [1:0]      w_nreq, w_nwr;
  logic [3:0]      w_first, w_second;
  logic            w_drop, w_toggle;

  assign w_kbd_ok = i_KBD_VALID && (i_KBD_VALUE >= 3'd1) && (i_KBD_VALUE <= 3'd5);
  assign w_btn_ok = i_BTN_VALID && (i_BTN_VALUE >= 3'd1) && (i_BTN_VALUE <= 3'd5);
  assign w_both   = w_kbd_ok && w_btn_ok;

  // HOLD at zero doubles as the IDLE decision so the spacing is exactly GAP.
  assign w_pop_slot = (r_state == IDLE) || ((r_state == HOLD) && (r_gap == 4'd0));
  assign w_pop      = w_pop_slot && (r_count != '0) && !i_FLUSH;
  assign w_free     = CW'(DEPTH) - r_count + CW'(w_pop);
  assign w_nreq     = {1'b0, w_kbd_ok} + {1'b0, w_btn_ok};

  always_comb begin
    w_first  = {1'b0, i_KBD_VALUE};
    w_second = {1'b1, i_BTN_VALUE};
    if (w_both && r_prio) begin
      w_first  = {1'b1, i_BTN_VALUE};
      w_second = {1'b0, i_KBD_VALUE};
    end else if (!w_kbd_ok) begin
      w_first  = {1'b1, i_BTN_VALUE};
    end
  end

  always_comb begin
    w_nwr = 2'd0;
    if (!i_FLUSH) begin
      if (w_free >= CW'(2))      w_nwr = w_nreq;
      else if (w_free == CW'(1)) w_nwr = (w_nreq != 2'd0) ? 2'd1 : 2'd0;
    end
  end

  assign w_drop   = !i_FLUSH && (w_nwr < w_nreq);
  assign w_toggle = !i_FLUSH && w_both && (w_nwr != 2'd0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_pop) w_next = ISSUE;
      ISSUE:   w_next = HOLD;
      HOLD:    if (r_gap == 4'd0) w_next = w_pop ? ISSUE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (RESET)                             r_gap <= 4'd0;
    else if (r_state == ISSUE)             r_gap <= 4'(GAP - 2);
    else if (r_state == HOLD && r_gap != 4'd0) r_gap <= r_gap - 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (w_nwr != 2'd0) r_mem[r_wr_ptr] <= w_first;
      if (w_nwr == 2'd2) r_mem[r_wr_ptr + AW'(1)] <= w_second;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_prio   <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= w_drop;
      if (w_toggle) r_prio <= ~r_prio;
      if (i_FLUSH) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + AW'(w_nwr);
        r_rd_ptr <= r_rd_ptr + AW'(w_pop);
        r_count  <= r_count + CW'(w_nwr) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_key_valid <= 1'b0;
      r_key_value <= 3'd0;
      r_key_src   <= 1'b0;
    end else if (w_pop) begin
      r_key_valid <= 1'b1;
      r_key_value <= r_mem[r_rd_ptr][2:0];
      r_key_src   <= r_mem[r_rd_ptr][3];
    end else begin
      r_key_valid <= 1'b0;
    end
  end

  assign o_KEY_VALID = r_key_valid;
  assign o_KEY_VALUE = r_key_value;
  assign o_KEY_SRC   = r_key_src;
  assign o_COUNT     = r_count;
  assign o_DROP      = r_drop;

endmodule

// File: tb/tb_key_arbiter.sv
// Directed and randomized checks of key_arbiter against a queue-based model
// built from the arbitration, spacing and flush rules.
module tb_key_arbiter;
  localparam int GAP   = 4;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [2:0] kbd_value = '0, btn_value = '0;
  logic       kbd_valid = 1'b0, btn_valid = 1'b0, flush = 1'b0;
  logic [2:0] key_value;
  logic       key_valid, key_src, drop;
  logic [$clog2(DEPTH):0] count;

  key_arbiter #(.GAP(GAP), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_KBD_VALUE(kbd_value), .i_KBD_VALID(kbd_valid),
    .i_BTN_VALUE(btn_value), .i_BTN_VALID(btn_valid),
    .i_FLUSH(flush),
    .o_KEY_VALUE(key_value), .o_KEY_VALID(key_valid), .o_KEY_SRC(key_src),
    .o_COUNT(count), .o_DROP(drop)
  );

  always #5 CLK = ~CLK;

  int nvec = 0, nerr = 0;

  // reference model
  logic [3:0] mq[$];
  logic       m_valid = 0, m_src = 0, m_drop = 0, m_prio = 0;
  logic [2:0] m_val = 0;
  int         m_cyc = 0, m_next = 0;

  task automatic model_edge(input logic kv, input logic [2:0] kc, input logic bv,
                            input logic [2:0] bc, input logic fl, input logic rs);
    logic kok, bok;
    logic [3:0] ent [2];
    logic [3:0] e;
    int nreq, free, pushed;
    if (rs) begin
      mq.delete();
      m_valid = 0; m_val = 0; m_src = 0; m_drop = 0; m_prio = 0; m_next = 0;
    end else begin
      m_drop = 0;
      if (mq.size() > 0 && !fl && m_cyc >= m_next) begin
        e = mq.pop_front();
        m_valid = 1; m_val = e[2:0]; m_src = e[3];
        m_next = m_cyc + GAP;
      end else m_valid = 0;
      if (fl) mq.delete();
      else begin
        kok = kv && kc >= 1 && kc <= 5;
        bok = bv && bc >= 1 && bc <= 5;
        nreq = 0;
        if (kok && bok) begin
          ent[0] = m_prio ? {1'b1, bc} : {1'b0, kc};
          ent[1] = m_prio ? {1'b0, kc} : {1'b1, bc};
          nreq = 2;
        end else if (kok) begin ent[0] = {1'b0, kc}; nreq = 1; end
        else if (bok)     begin ent[0] = {1'b1, bc}; nreq = 1; end
        free = DEPTH - mq.size();
        pushed = 0;
        for (int i = 0; i < nreq; i++)
          if (pushed < free) begin mq.push_back(ent[i]); pushed++; end
        if (pushed < nreq) m_drop = 1;
        if (kok && bok && pushed > 0) m_prio = ~m_prio;
      end
    end
    m_cyc++;
  endtask

  task automatic step(input logic kv, input logic [2:0] kc, input logic bv,
                      input logic [2:0] bc, input logic fl, input logic rs);
    @(negedge CLK);
    kbd_valid = kv; kbd_value = kc; btn_valid = bv; btn_value = bc;
    flush = fl; RESET = rs;
    @(posedge CLK);
    model_edge(kv, kc, bv, bc, fl, rs);
    #1;
  endtask

  task automatic idle();
    step(0, 3'd0, 0, 3'd0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 3'd0, 0, 3'd0, 0, 1);
    step(0, 3'd0, 0, 3'd0, 0, 1);
  endtask

  task automatic test_reset();
    step(1, 3'd5, 1, 3'd3, 1, 1);
    step(1, 3'd2, 1, 3'd1, 1, 1);
    nvec++;
    if ({key_valid, key_value, key_src, count, drop} !== '0) begin
      nerr++; $display("FAIL reset_outputs: got v=%b val=%0d src=%b cnt=%0d drop=%b want all 0",
                       key_valid, key_value, key_src, count, drop);
    end
    idle();
    nvec++;
    if (count !== 0 || key_valid !== 0) begin
      nerr++; $display("FAIL reset_idle: got cnt=%0d v=%b want 0 0", count, key_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    repeat (3) idle();
    step(1, 3'd5, 0, 3'd0, 0, 0);
    nvec++;
    if (count !== 1 || key_valid !== 0) begin
      nerr++; $display("FAIL single_write: got cnt=%0d v=%b want 1 0", count, key_valid);
    end
    idle();
    nvec++;
    if (key_valid !== 1 || key_value !== 5 || key_src !== 0) begin
      nerr++; $display("FAIL single_issue: got v=%b val=%0d src=%b want 1 5 0", key_valid, key_value, key_src);
    end
    idle();
    nvec++;
    if (key_valid !== 0 || key_value !== 5 || count !== 0) begin
      nerr++; $display("FAIL single_hold: got v=%b val=%0d cnt=%0d want 0 5 0", key_valid, key_value, count);
    end
  endtask

  task automatic test_spacing();
    int pk[$], pv[$];
    int maxc;
    do_reset();
    maxc = 0;
    for (int k = 0; k < 15; k++) begin
      if (k < 3) step(1, 3'(k + 1), 0, 3'd0, 0, 0);
      else idle();
      if (key_valid) begin pk.push_back(k); pv.push_back(key_value); end
      if (count > maxc) maxc = count;
    end
    nvec++;
    if (pk.size() != 3) begin
      nerr++; $display("FAIL spacing_npulses: got %0d want 3", pk.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (pk[i] != 1 + GAP * i || pv[i] != i + 1) begin
          nerr++; $display("FAIL spacing_pulse%0d: got step=%0d val=%0d want step=%0d val=%0d",
                           i, pk[i], pv[i], 1 + GAP * i, i + 1);
        end
      end
    end
    nvec++;
    if (maxc != 2) begin
      nerr++; $display("FAIL spacing_peak: got %0d want 2", maxc);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] got[$];
    logic [3:0] exp_s [4];
    exp_s[0] = {1'b0, 3'd2}; exp_s[1] = {1'b1, 3'd4};
    exp_s[2] = {1'b1, 3'd4}; exp_s[3] = {1'b0, 3'd2};
    do_reset();
    for (int k = 0; k < 20; k++) begin
      if (k < 2) step(1, 3'd2, 1, 3'd4, 0, 0);
      else idle();
      if (key_valid) got.push_back({key_src, key_value});
    end
    nvec++;
    if (got.size() != 4) begin
      nerr++; $display("FAIL simul_npulses: got %0d want 4", got.size());
    end else
      for (int i = 0; i < 4; i++) begin
        nvec++;
        if (got[i] !== exp_s[i]) begin
          nerr++; $display("FAIL simul_order%0d: got src=%b val=%0d want src=%b val=%0d",
                           i, got[i][3], got[i][2:0], exp_s[i][3], exp_s[i][2:0]);
        end
      end
  endtask

  task automatic test_overflow();
    do_reset();
    step(1, 3'd1, 1, 3'd2, 0, 0);
    step(1, 3'd4, 1, 3'd5, 0, 0);
    nvec++;
    if (count !== 3 || key_valid !== 1 || key_value !== 1) begin
      nerr++; $display("FAIL ovf_fill: got cnt=%0d v=%b val=%0d want 3 1 1", count, key_valid, key_value);
    end
    step(1, 3'd1, 1, 3'd3, 0, 0);
    nvec++;
    if (count !== 4 || drop !== 1) begin
      nerr++; $display("FAIL ovf_simul: got cnt=%0d drop=%b want 4 1", count, drop);
    end
    step(1, 3'd5, 0, 3'd0, 0, 0);
    nvec++;
    if (count !== 4 || drop !== 1) begin
      nerr++; $display("FAIL ovf_full_single: got cnt=%0d drop=%b want 4 1", count, drop);
    end
    idle();
    nvec++;
    if (drop !== 0) begin
      nerr++; $display("FAIL ovf_drop_width: got drop=%b want 0", drop);
    end
    step(0, 3'd0, 1, 3'd3, 0, 0);
    nvec++;
    if (count !== 4 || drop !== 0 || key_valid !== 1 || key_value !== 2 || key_src !== 1) begin
      nerr++; $display("FAIL ovf_pop_frees: got cnt=%0d drop=%b v=%b val=%0d src=%b want 4 0 1 2 1",
                       count, drop, key_valid, key_value, key_src);
    end
  endtask

  task automatic test_filter_flush();
    int nv;
    do_reset();
    step(0, 3'd0, 1, 3'd7, 0, 0);
    step(1, 3'd0, 1, 3'd6, 0, 0);
    nvec++;
    if (count !== 0 || drop !== 0) begin
      nerr++; $display("FAIL filter: got cnt=%0d drop=%b want 0 0", count, drop);
    end
    step(1, 3'd1, 1, 3'd2, 0, 0);
    step(1, 3'd3, 1, 3'd4, 0, 0);
    nvec++;
    if (count !== 3 || key_valid !== 1) begin
      nerr++; $display("FAIL flush_pre: got cnt=%0d v=%b want 3 1", count, key_valid);
    end
    step(1, 3'd5, 0, 3'd0, 1, 0);
    nvec++;
    if (count !== 0) begin
      nerr++; $display("FAIL flush_count: got %0d want 0", count);
    end
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      idle();
      if (key_valid) nv++;
    end
    nvec++;
    if (nv != 0 || count !== 0) begin
      nerr++; $display("FAIL flush_quiet: got pulses=%0d cnt=%0d want 0 0", nv, count);
    end
  endtask

  task automatic test_reset_hold();
    do_reset();
    step(1, 3'd1, 0, 3'd0, 0, 0);
    step(1, 3'd2, 0, 3'd0, 0, 0);
    idle();
    step(0, 3'd0, 0, 3'd0, 1, 1);
    nvec++;
    if (count !== 0 || key_valid !== 0 || key_value !== 0) begin
      nerr++; $display("FAIL rsthold_reset: got cnt=%0d v=%b val=%0d want 0 0 0", count, key_valid, key_value);
    end
    step(1, 3'd4, 0, 3'd0, 0, 0);
    nvec++;
    if (count !== 1 || key_valid !== 0) begin
      nerr++; $display("FAIL rsthold_write: got cnt=%0d v=%b want 1 0", count, key_valid);
    end
    idle();
    nvec++;
    if (key_valid !== 1 || key_value !== 4 || key_src !== 0) begin
      nerr++; $display("FAIL rsthold_issue: got v=%b val=%0d src=%b want 1 4 0", key_valid, key_value, key_src);
    end
  endtask

  task automatic test_random();
    logic kv, bv, fl, rs;
    logic [2:0] kc, bc;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      kv = ($urandom_range(0, 1) == 1);
      bv = ($urandom_range(0, 2) == 0);
      kc = 3'($urandom_range(0, 7));
      bc = 3'($urandom_range(0, 7));
      fl = ($urandom_range(0, 59) == 0);
      rs = ($urandom_range(0, 249) == 0);
      if (k % 400 > 300) begin kv = 0; bv = 0; end
      step(kv, kc, bv, bc, fl, rs);
      nvec++;
      if (key_valid !== m_valid || key_value !== m_val || key_src !== m_src ||
          drop !== m_drop || {29'd0, count} !== 32'(mq.size())) begin
        nerr++;
        $display("FAIL random@%0d: got v=%b val=%0d src=%b drop=%b cnt=%0d want v=%b val=%0d src=%b drop=%b cnt=%0d",
                 k, key_valid, key_value, key_src, drop, count,
                 m_valid, m_val, m_src, m_drop, mq.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_spacing();
    test_simultaneous();
    test_overflow();
    test_filter_flush();
    test_reset_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
